prbs31_tx_gen: RTL
==================

# prbs31_tx_gen

- Parallel PRBS31 pattern source for the 64-bit lane at 390.625 MHz.
- Uses G(x) = x^31 + x^28 + 1 and emits one 64-bit word per enabled cycle.
- Sits directly upstream of the RX BER monitor: its output feeds the serializer, or the CDR data path in loopback.
- Supports deterministic single-shot and periodic bit-error injection, so the downstream bit-error count can be checked against a known injected-error count.

## Interface

Parameters:
- SEED, 31'h7FFF_FFFF: generator state after reset, and the substitute when an all-zero seed is loaded.
- PERIOD_W, 16: width of the injection period and the injection counter.

Ports:
- clk_390p625M  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- gen_EN  in  1  advance the generator and emit one word this cycle.
- seed_load  in  1  load seed_in into the generator state.
- seed_in  in  31  seed value; bit j = s[-31+j].
- inj_single  in  1  one-cycle request to inject one error.
- inj_bit_sel  in  6  index of the bit to flip in an injected word.
- inj_period_EN  in  1  enable periodic injection.
- inj_period  in  PERIOD_W  words per injection period; 0 disables periodic injection.
- prbs_data  out  64  pattern word; bit 0 is transmitted first.
- prbs_valid  out  1  prbs_data updated this cycle.
- inj_count  out  PERIOD_W  saturating total of injected errors.

## Operation

Sequence definition:
- s[n] = s[n-28] XOR s[n-31].
- Word k has bit i = s[64k+i].
- The 31-bit state holds the last 31 sequence bits emitted: st[j] = s[64k-31+j].
- The next word and next state are computed combinationally and fully unrolled over 64 bits. No multi-cycle iteration.

Seed load:
- seed_load=1 sets st to seed_in, or to SEED if seed_in==0.
- prbs_valid <= 0; prbs_data holds.
- Pending single injection is cleared; the period counter is cleared to 0.
- seed_load has priority over gen_EN.

Generate:
- gen_EN=1 with seed_load=0: prbs_data <= next word XOR injection mask, st advances, prbs_valid <= 1.
- st always advances from the clean, uninjected word. An injected error never propagates into later words.

Idle:
- gen_EN=0: prbs_data, st and the period counter hold; prbs_valid <= 0.

Single-shot injection:
- inj_single=1 on any cycle sets a pending flag. Repeated requests while pending merge into one.
- The flag is consumed by the next emitted word: bit inj_bit_sel is inverted, the flag is cleared, and inj_count increments.
- If inj_single and emission coincide on the same edge, that word is injected.

Periodic injection:
- The period counter increments on every emitted word.
- While inj_period_EN=1 and inj_period!=0, the word emitted when the counter equals inj_period-1 is injected, and the counter wraps to 0.
- inj_period=1 injects every word.
- inj_period_EN=0 or inj_period=0: the counter is held at 0.
- A change of inj_period takes effect on the next comparison.
- If the counter is already ≥ the new inj_period-1, the counter wraps at its next increment and injects then.

Coincidence:
- Single and periodic injection on the same word produce one flipped bit, a single +1 on inj_count, and clear the pending flag.

Counter width:
- inj_count saturates at all-ones. It is cleared only by rst.

## Timing

Reset:
- rst=1 at an edge forces:
  - st = SEED
  - prbs_data = 0
  - prbs_valid = 0
  - inj_count = 0
  - pending flag = 0
  - period counter = 0
- rst has priority over every other input.
- A reset mid-stream restarts the sequence at word 0 of SEED.

Latency:
- gen_EN sampled at edge t gives the word on prbs_data and prbs_valid=1 after edge t.
- There is one register stage from state to output.
- With gen_EN held high, throughput is one word per cycle, with no bubbles.

inj_count timing:
- inj_count updates on the same edge that emits the injected word.

seed_load timing:
- The first word after seed_load is emitted on the first gen_EN edge that follows it. That word is s[0..63] of the new seed.

## Test plan

- **Reset, first word:** rst for 2 cycles, then gen_EN=1 → first prbs_valid word = 64'h3F00_0000_7000_0000; prbs_valid deasserts the cycle after gen_EN drops.
- **Sequence check:** run 10,000 words through a bit-serial reference LFSR → every word matches; no gap in prbs_valid.
- **Single injection:** pulse inj_single with inj_bit_sel=0 before word 0 → word 0 = 64'h3F00_0000_7000_0001; word 1 equals the clean reference; inj_count=1.
- **Periodic injection:** inj_period=4, inj_period_EN=1, inj_bit_sel=63 → words 3, 7, 11… have bit 63 inverted; after 40 words, inj_count=10. A coincident inj_single on word 7 leaves inj_count=10.
- **Zero seed, priority:** seed_load=1 with seed_in=0 and gen_EN=1 in the same cycle → no valid that cycle; the next word = 64'h3F00_0000_7000_0000.
- **Reset mid-stream, saturation:** rst during continuous generation → outputs are 0 the next cycle and the restart word matches word 0. Separately, with inj_period=1 for 70,000 words → inj_count sticks at 16'hFFFF.

Source files
------------

// File: rtl/prbs31_tx_gen.sv
// PRBS31 (x^31 + x^28 + 1) 64-bit parallel pattern source with single-shot and periodic bit-error injection.
// One register stage from state to output; one word per gen_EN cycle; no backpressure, idle simply holds.
module prbs31_tx_gen #(
  parameter logic [30:0] SEED     = 31'h7FFF_FFFF,
  parameter int          PERIOD_W = 16
) (
  input  logic                clk_390p625M,
  input  logic                rst,
  input  logic                gen_EN,
  input  logic                seed_load,
  input  logic [30:0]         seed_in,
  input  logic                inj_single,
  input  logic [5:0]          inj_bit_sel,
  input  logic                inj_period_EN,
  input  logic [PERIOD_W-1:0] inj_period,
  output logic [63:0]         prbs_data,
  output logic                prbs_valid,
  output logic [PERIOD_W-1:0] inj_count
);

  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

  // Bits [30:0] are the current state, [94:31] the next 64 sequence bits (bit 31 = word bit 0).
  function automatic logic [94:0] prbs_expand(input logic [30:0] st_in);
    logic [94:0] e;
    e        = '0;
    e[30:0]  = st_in;
    for (int i = 0; i < 64; i++) begin
      e[31+i] = e[i+3] ^ e[i];
    end
    return e;
  endfunction

  logic [30:0]         st;
  logic                pending;
  logic [PERIOD_W-1:0] per_cnt;

  logic [94:0]         ext;
  logic [63:0]         word_clean;
  logic [30:0]         st_next;
  logic                emit;
  logic                period_active;
  logic                period_hit;
  logic                inject;
  logic [63:0]         inj_mask;

  assign ext           = prbs_expand(st);
  assign word_clean    = ext[94:31];
  assign st_next       = ext[94:64];
  assign emit          = gen_EN & ~seed_load;
  assign period_active = inj_period_EN && (inj_period != '0);
  // >= rather than == so a shortened period still wraps on the next word.
  assign period_hit    = period_active && (per_cnt >= (inj_period - CNT_ONE));
  assign inject        = emit & (pending | inj_single | period_hit);
  assign inj_mask      = inject ? (64'd1 << inj_bit_sel) : 64'd0;

  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      st         <= SEED;
      prbs_data  <= '0;
      prbs_valid <= 1'b0;
      inj_count  <= '0;
      pending    <= 1'b0;
      per_cnt    <= '0;
    end else begin
      if (seed_load) begin
        st         <= (seed_in == '0) ? SEED : seed_in;
        prbs_valid <= 1'b0;
        pending    <= 1'b0;
        per_cnt    <= '0;
      end else if (emit) begin
        // State advances from the clean word so injected errors never propagate.
        st         <= st_next;
        prbs_data  <= word_clean ^ inj_mask;
        prbs_valid <= 1'b1;
        pending    <= 1'b0;
        if (!period_active || period_hit) per_cnt <= '0;
        else                              per_cnt <= per_cnt + CNT_ONE;
      end else begin
        prbs_valid <= 1'b0;
        pending    <= pending | inj_single;
        if (!period_active) per_cnt <= '0;
      end

      if (inject && (inj_count != CNT_MAX)) inj_count <= inj_count + CNT_ONE;
    end
  end

endmodule
